// File: rtl/hive_reg_midi_rx.sv
// MIDI serial receiver (8,n,1, LSB first) with a byte FIFO behind one rbus status/data register.
// Optional build macro MIDI_RX_REALTIME_FILTER_EN drops timing-clock (F8) and active-sensing (FE) bytes.
module hive_reg_midi_rx #(
    parameter int                     ALU_W       = 32,
    parameter int                     RBUS_ADDR_W = 4,
    parameter logic [RBUS_ADDR_W-1:0] ADDR        = 4'hB,
    parameter int                     DATA_W      = 8,
    parameter int                     CLK_HZ      = 180000000,
    parameter int                     BAUD_HZ     = 31250,
    parameter int                     FIFO_ADDR_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
    input  logic                   rbus_wr_i,
    input  logic                   rbus_rd_i,
    input  logic [ALU_W-1:0]       rbus_wr_data_i,
    output logic [ALU_W-1:0]       rbus_rd_data_o,
    input  logic                   midi_rx_i
);

    localparam int BIT_DIV = (CLK_HZ + BAUD_HZ / 2) / BAUD_HZ;
    localparam int CNT_W   = $clog2(BIT_DIV);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DEPTH   = 1 << FIFO_ADDR_W;

    localparam logic [CNT_W-1:0]       CNT_HALF  = CNT_W'(BIT_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]       CNT_FULL  = CNT_W'(BIT_DIV - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [FIFO_ADDR_W:0]   CNT_DEPTH = (FIFO_ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BRK
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_W:0]   count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic [ALU_W-1:0]       rd_data_q, rd_data_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic              line;
    logic              fall;
    logic              byte_done;
    logic              frame_set;
    logic              is_rt;
    logic              rd_hit;
    logic              wr_hit;
    logic              not_empty;
    logic              full;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              overrun_set;
    logic [DATA_W-1:0] head;
    logic              unused_wr_data;

    assign unused_wr_data = ^rbus_wr_data_i;

    assign line = sync2_q;
    assign fall = ~sync2_q & prev_q;

`ifdef MIDI_RX_REALTIME_FILTER_EN
    assign is_rt = (shift_q == DATA_W'(8'hF8)) || (shift_q == DATA_W'(8'hFE));
`else
    assign is_rt = 1'b0;
`endif

    always_comb begin
        sync1_d   = midi_rx_i;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_set = 1'b0;

        // Each state waits for the bit counter to expire, then samples mid-bit.
        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    cnt_d   = CNT_HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!line) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {line, shift_q[DATA_W-1:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (line) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BRK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BRK: begin
                if (line) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_hit      = rbus_rd_i && (rbus_addr_i == ADDR);
        wr_hit      = rbus_wr_i && (rbus_addr_i == ADDR);
        not_empty   = (count_q != '0);
        full        = (count_q == CNT_DEPTH);
        head        = not_empty ? mem_q[rd_ptr_q] : '0;
        pop         = rd_hit & not_empty;
        push_req    = byte_done & ~is_rt & ~wr_hit;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push_ok     = push_req & (~full | pop);
        overrun_set = push_req & full & ~pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_hit) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_d = count_q - 1'b1;
            end
        end

        overrun_d   = overrun_set | (overrun_q & ~rd_hit & ~wr_hit);
        frame_err_d = frame_set | (frame_err_q & ~rd_hit & ~wr_hit);

        rd_data_d = '0;
        if (rd_hit) begin
            rd_data_d[ALU_W-1]    = not_empty;
            rd_data_d[ALU_W-2]    = overrun_q;
            rd_data_d[ALU_W-3]    = frame_err_q;
            rd_data_d[DATA_W-1:0] = head;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by count_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rbus_rd_data_o = rd_data_q;

endmodule

// File: tb/tb_hive_reg_midi_rx.sv
// Scoreboard bench for hive_reg_midi_rx: directed serial frames, register reads checked by a monitor.
module tb_hive_reg_midi_rx;

    localparam int         CLK_HZ      = 3125000;
    localparam int         BAUD_HZ     = 31250;
    localparam int         BIT_DIV     = 100;
    localparam int         FIFO_ADDR_W = 2;
    localparam logic [3:0] REG_ADDR    = 4'hB;

    logic        clk;
    logic        rst;
    logic [3:0]  rbusAddr;
    logic        rbusWr;
    logic        rbusRd;
    logic [31:0] rbusWrData;
    logic [31:0] rbusRdData;
    logic        midiRx;

    logic [31:0] expQ [$];
    string       nameQ [$];
    int          checksDone;
    int          checksPassed;

    hive_reg_midi_rx #(
        .ALU_W      (32),
        .RBUS_ADDR_W(4),
        .ADDR       (REG_ADDR),
        .DATA_W     (8),
        .CLK_HZ     (CLK_HZ),
        .BAUD_HZ    (BAUD_HZ),
        .FIFO_ADDR_W(FIFO_ADDR_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rbus_addr_i   (rbusAddr),
        .rbus_wr_i     (rbusWr),
        .rbus_rd_i     (rbusRd),
        .rbus_wr_data_i(rbusWrData),
        .rbus_rd_data_o(rbusRdData),
        .midi_rx_i     (midiRx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksDone++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drives one 8,n,1 frame on the serial line, LSB first.
    task automatic applyStimulus(input logic [7:0] b);
        midiRx = 1'b0;
        repeat (BIT_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midiRx = b[i];
            repeat (BIT_DIV) @(negedge clk);
        end
        midiRx = 1'b1;
        repeat (BIT_DIV) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        midiRx = 1'b1;
        repeat (n * BIT_DIV) @(negedge clk);
    endtask

    task automatic regRead(input string name, input logic [31:0] expected);
        @(negedge clk);
        expQ.push_back(expected);
        nameQ.push_back(name);
        rbusAddr = REG_ADDR;
        rbusRd   = 1'b1;
        @(negedge clk);
        rbusRd   = 1'b0;
        rbusAddr = 4'h0;
    endtask

    task automatic regWrite(input logic [31:0] value);
        @(negedge clk);
        rbusAddr   = REG_ADDR;
        rbusWrData = value;
        rbusWr     = 1'b1;
        @(negedge clk);
        rbusWr     = 1'b0;
        rbusAddr   = 4'h0;
    endtask

    // Monitor: a register read presents data one cycle later; compare against the scoreboard head.
    initial begin
        logic        rdSeen;
        logic [31:0] expVal;
        string       expName;
        forever begin
            @(posedge clk);
            rdSeen = rbusRd && (rbusAddr == REG_ADDR) && !rst;
            @(negedge clk);
            if (rdSeen) begin
                if (expQ.size() == 0) begin
                    checksDone++;
                    $display("[TB] FAIL unexpected read: got %h expected no read", rbusRdData);
                end else begin
                    expVal  = expQ.pop_front();
                    expName = nameQ.pop_front();
                    checkOutput(expName, rbusRdData, expVal);
                end
            end
        end
    end

    initial begin
        checksDone   = 0;
        checksPassed = 0;
        rst        = 1'b1;
        midiRx     = 1'b1;
        rbusAddr   = 4'h0;
        rbusWr     = 1'b0;
        rbusRd     = 1'b0;
        rbusWrData = 32'h0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset rd_data", rbusRdData, 32'h0);
        regRead("read after reset", 32'h0000_0000);

        idleBits(1);
        applyStimulus(8'h90);
        regRead("single 90", 32'h8000_0090);
        regRead("single then empty", 32'h0000_0000);

        applyStimulus(8'h3C);
        applyStimulus(8'h7F);
        regRead("b2b first 3C", 32'h8000_003C);
        regRead("b2b second 7F", 32'h8000_007F);
        regRead("b2b then empty", 32'h0000_0000);

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i));
        end
        regRead("overrun 01", 32'hC000_0001);
        regRead("overrun 02", 32'h8000_0002);
        regRead("overrun 03", 32'h8000_0003);
        regRead("overrun 04", 32'h8000_0004);
        regRead("overrun drained", 32'h0000_0000);

        midiRx = 1'b0;
        repeat (20 * BIT_DIV) @(negedge clk);
        idleBits(2);
        regRead("break frame_err", 32'h2000_0000);
        regRead("frame_err cleared", 32'h0000_0000);
        applyStimulus(8'hA5);
        regRead("after break A5", 32'h8000_00A5);

        midiRx = 1'b0;
        repeat (30) @(negedge clk);
        idleBits(2);
        regRead("glitch ignored", 32'h0000_0000);

        applyStimulus(8'h11);
        @(negedge clk);
        rbusAddr = 4'h3;
        rbusRd   = 1'b1;
        @(negedge clk);
        rbusRd   = 1'b0;
        rbusAddr = 4'h0;
        checkOutput("other address reads 0", rbusRdData, 32'h0);
        regRead("no pop on other address", 32'h8000_0011);

        applyStimulus(8'h22);
        applyStimulus(8'h33);
        regWrite(32'hDEAD_BEEF);
        regRead("flush by write", 32'h0000_0000);
        applyStimulus(8'h44);
        regRead("after flush 44", 32'h8000_0044);

        applyStimulus(8'hF8);
        applyStimulus(8'h90);
        applyStimulus(8'hFE);
`ifdef MIDI_RX_REALTIME_FILTER_EN
        regRead("filter 90 only", 32'h8000_0090);
        regRead("filter then empty", 32'h0000_0000);
`else
        regRead("rt F8", 32'h8000_00F8);
        regRead("rt 90", 32'h8000_0090);
        regRead("rt FE", 32'h8000_00FE);
        regRead("rt then empty", 32'h0000_0000);
`endif

        repeat (5) @(negedge clk);
        if (expQ.size() != 0) begin
            checksDone++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
